// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART framing FSMs (receive and transmit side).
// Frame layout on the wire: HEADER, LO, HI, CHK with CHK = HEADER ^ LO ^ HI.
// Contents:
//   frame_state_t   - state encoding of the frame FSMs
//   DEFAULT_HEADER  - default frame start byte
//   DEFAULT_TIMEOUT - default maximum clk cycles between bytes of one frame
//   frame_chk()     - checksum over header and payload bytes
package uart_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RECV_LO  = 2'd1,
    ST_RECV_HI  = 2'd2,
    ST_RECV_CHK = 2'd3
  } frame_state_t;

  localparam logic [7:0]  DEFAULT_HEADER  = 8'hA5;
  localparam logic [15:0] DEFAULT_TIMEOUT = 16'd1000;

  function automatic logic [7:0] frame_chk(input logic [7:0] hdr,
                                           input logic [7:0] lo,
                                           input logic [7:0] hi);
    return hdr ^ lo ^ hi;
  endfunction

endpackage

// File: rtl/fsm_receive_data_if.sv
// Bundle between the UART byte receiver, the frame FSM and its consumer.
// Signals:
//   rx_ready   - one-cycle strobe: a new byte is on rx_data
//   rx_data    - received byte, meaningful only while rx_ready=1
//   data_out   - last accepted frame payload {HI, LO}
//   data_valid - one-cycle pulse when data_out is updated
//   frame_err  - one-cycle pulse on checksum failure or inter-byte timeout
//   busy       - high while a frame is partially received
// Handshake: rx_ready is a strobe with no back-pressure. A byte is transferred
// on every rising clk edge where rx_ready=1; the frame FSM is always able to
// take it, so there is no ready signal in the receive direction. data_valid
// and frame_err are likewise single-cycle strobes that the consumer must
// sample on the cycle they are high.
interface fsm_receive_data_if;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic [15:0] data_out;
  logic        data_valid;
  logic        frame_err;
  logic        busy;

  // Byte source / result consumer side.
  modport master (
    output rx_ready, rx_data,
    input  data_out, data_valid, frame_err, busy
  );

  // Frame FSM side.
  modport slave (
    input  rx_ready, rx_data,
    output data_out, data_valid, frame_err, busy
  );
endinterface

// File: rtl/frame_timeout_timer.sv
// Inter-byte timer for the frame FSM. Counts clk cycles while run=1,
// returns to 0 on clear or whenever run=0, and saturates instead of wrapping.
// Ports:
//   clk, reset - clock, asynchronous active-high reset
//   clear      - zero the count at the next edge
//   run        - count while high; held at 0 while low
//   expired    - count has reached TIMEOUT
module frame_timeout_timer
  import uart_frame_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  logic [15:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 16'd0;
    end else if (clear || !run) begin
      count_q <= 16'd0;
    end else if (count_q != 16'hFFFF) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign expired = (count_q >= TIMEOUT);

endmodule

// File: rtl/fsm_receive_data.sv
// Receives 4-byte frames (HEADER, LO, HI, CHK) from a UART byte stream.
// A frame with a good checksum loads data_out={HI,LO} and pulses data_valid;
// a bad checksum or a gap longer than TIMEOUT cycles between bytes pulses
// frame_err and drops the partial frame. Outside a frame, non-HEADER bytes
// are ignored silently.
// Ports:
//   clk       - clock, rising edge active
//   reset     - asynchronous active-high reset
//   bus       - fsm_receive_data_if.slave (rx strobe/data in, results out)
//   state_dbg - current FSM state, for observation only
module fsm_receive_data
  import uart_frame_pkg::*;
#(
  parameter logic [7:0]  HEADER  = DEFAULT_HEADER,
  parameter logic [15:0] TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  fsm_receive_data_if.slave   bus,
  output frame_state_t        state_dbg
);

  frame_state_t state_q, state_d;
  logic [7:0]   lo_q, lo_d;
  logic [7:0]   hi_q, hi_d;
  logic [15:0]  data_out_q, data_out_d;
  logic         valid_q, valid_d;
  logic         err_q, err_d;
  logic         expired;
  logic         timer_clear;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      lo_q       <= 8'd0;
      hi_q       <= 8'd0;
      data_out_q <= 16'd0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  // In the RECV_* states an incoming byte always takes priority over the
  // timeout: the timeout branch is only reached when rx_ready is low.
  always_comb begin
    state_d    = state_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.rx_ready && (bus.rx_data == HEADER)) begin
          state_d = ST_RECV_LO;
        end
      end
      ST_RECV_LO: begin
        if (bus.rx_ready) begin
          lo_d    = bus.rx_data;
          state_d = ST_RECV_HI;
        end else if (expired) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          lo_d    = 8'd0;
          hi_d    = 8'd0;
        end
      end
      ST_RECV_HI: begin
        if (bus.rx_ready) begin
          hi_d    = bus.rx_data;
          state_d = ST_RECV_CHK;
        end else if (expired) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          lo_d    = 8'd0;
          hi_d    = 8'd0;
        end
      end
      ST_RECV_CHK: begin
        if (bus.rx_ready) begin
          state_d = ST_IDLE;
          if (bus.rx_data == frame_chk(HEADER, lo_q, hi_q)) begin
            data_out_d = {hi_q, lo_q};
            valid_d    = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (expired) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          lo_d    = 8'd0;
          hi_d    = 8'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Restart the gap measurement on any state change and on every byte taken
  // inside a frame (IDLE keeps the timer parked at 0 through run=0).
  assign timer_clear = (state_d != state_q) ||
                       (bus.rx_ready && (state_q != ST_IDLE));

  frame_timeout_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .run     (state_q != ST_IDLE),
    .expired (expired)
  );

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = valid_q;
  assign bus.frame_err  = err_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_fsm_receive_data.sv
module tb_fsm_receive_data;
  import uart_frame_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fsm_receive_data_if bus();
  frame_state_t       state_dbg;

  fsm_receive_data dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Called at a falling edge; the byte is sampled at the next rising edge and
  // the task returns at the following falling edge, where registered results
  // of that byte are visible.
  task automatic send_byte(input logic [7:0] b);
    bus.rx_ready = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_ready = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] chk);
    send_byte(8'hA5);
    send_byte(lo);
    send_byte(hi);
    send_byte(chk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int wait_cycles;
    reset        = 1'b1;
    bus.rx_ready = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_data_out",   bus.data_out,          16'h0000);
    check("rst_data_valid", 16'(bus.data_valid),   16'h0);
    check("rst_frame_err",  16'(bus.frame_err),    16'h0);
    check("rst_busy",       16'(bus.busy),         16'h0);
    check("rst_state",      16'(state_dbg),        16'(ST_IDLE));
    reset = 1'b0;
    @(negedge clk);

    // Valid frame: A5,34,12,83 (83 = A5^34^12)
    send_byte(8'hA5);
    check("v1_busy_after_hdr", 16'(bus.busy), 16'h1);
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'h83);
    check("v1_data_valid", 16'(bus.data_valid), 16'h1);
    check("v1_data_out",   bus.data_out,        16'h1234);
    check("v1_frame_err",  16'(bus.frame_err),  16'h0);
    @(negedge clk);
    check("v1_valid_pulse_end", 16'(bus.data_valid), 16'h0);
    check("v1_busy_after",      16'(bus.busy),       16'h0);

    // Timeout: A5,34 then silence. Timer is 0 in the cycle after the LO byte,
    // reaches 1000 in the 1000th cycle after it, the exit edge follows, so
    // frame_err is first seen at falling edge 1001.
    send_byte(8'hA5);
    send_byte(8'h34);
    wait_cycles = 0;
    for (int j = 1; j <= 1200; j++) begin
      @(negedge clk);
      if (bus.frame_err === 1'b1) begin
        wait_cycles = j;
        break;
      end
    end
    check("to_err_cycle", 16'(wait_cycles),     16'd1001);
    check("to_state",     16'(state_dbg),       16'(ST_IDLE));
    check("to_valid",     16'(bus.data_valid),  16'h0);
    check("to_data_out",  bus.data_out,         16'h1234);
    @(negedge clk);
    check("to_err_pulse_end", 16'(bus.frame_err), 16'h0);
    send_frame(8'hCD, 8'hAB, 8'hC3);
    check("to_next_valid",    16'(bus.data_valid), 16'h1);
    check("to_next_data_out", bus.data_out,        16'hABCD);

    // Bad checksum: data_out keeps ABCD
    send_frame(8'h34, 8'h12, 8'h00);
    check("bad_frame_err", 16'(bus.frame_err),  16'h1);
    check("bad_valid",     16'(bus.data_valid), 16'h0);
    check("bad_data_out",  bus.data_out,        16'hABCD);
    @(negedge clk);
    check("bad_err_pulse_end", 16'(bus.frame_err), 16'h0);
    check("bad_busy",          16'(bus.busy),      16'h0);

    // Noise before a frame is ignored silently
    send_byte(8'h00);
    check("noise00_err",  16'(bus.frame_err), 16'h0);
    check("noise00_busy", 16'(bus.busy),      16'h0);
    send_byte(8'hFF);
    check("noiseFF_err",  16'(bus.frame_err), 16'h0);
    check("noiseFF_busy", 16'(bus.busy),      16'h0);
    send_frame(8'h34, 8'h12, 8'h83);
    check("noise_frame_valid", 16'(bus.data_valid), 16'h1);
    check("noise_frame_data",  bus.data_out,        16'h1234);

    // Byte arriving in the cycle where timer == TIMEOUT wins over the timeout
    send_byte(8'hA5);
    send_byte(8'h78);
    repeat (1000) @(negedge clk);
    send_byte(8'h56);
    check("bnd_no_err", 16'(bus.frame_err), 16'h0);
    check("bnd_state",  16'(state_dbg),     16'(ST_RECV_CHK));
    send_byte(8'h8B);  // A5^78^56
    check("bnd_valid",    16'(bus.data_valid), 16'h1);
    check("bnd_data_out", bus.data_out,        16'h5678);

    // HEADER value inside a frame is data: A5,A5,12,12 (12 = A5^A5^12)
    send_frame(8'hA5, 8'h12, 8'h12);
    check("hdr_data_valid", 16'(bus.data_valid), 16'h1);
    check("hdr_data_out",   bus.data_out,        16'h12A5);

    // Asynchronous reset between LO and HI
    send_byte(8'hA5);
    send_byte(8'h34);
    #2 reset = 1'b1;
    #1;
    check("arst_data_out", bus.data_out,        16'h0000);
    check("arst_busy",     16'(bus.busy),       16'h0);
    check("arst_state",    16'(state_dbg),      16'(ST_IDLE));
    check("arst_err",      16'(bus.frame_err),  16'h0);
    check("arst_valid",    16'(bus.data_valid), 16'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("arst_after_err", 16'(bus.frame_err), 16'h0);
    send_frame(8'h78, 8'h56, 8'h8B);
    check("arst_next_valid", 16'(bus.data_valid), 16'h1);
    check("arst_next_data",  bus.data_out,        16'h5678);
    check("arst_next_err",   16'(bus.frame_err),  16'h0);
    @(negedge clk);
    check("arst_next_busy",  16'(bus.busy),       16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
